// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// with a start/busy/done handshake and registered result.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] MDresult
);

  typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_t;

  state_t      state_r, state_s;
  logic [5:0]  cnt_r;
  logic [63:0] acc_r;
  logic [31:0] b_r;
  logic [2:0]  op_r;
  logic        a_neg_r, neg_r, div0_r, ovf_r;
  logic        busy_r, done_r;
  logic [31:0] result_r;

  logic        is_div_s, sign_a_s, sign_b_s, a_neg_s, b_neg_s, div0_s, ovf_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic [32:0] mul_sum_s, trial_s;
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s, result_s;

  assign is_div_s  = op[2];
  assign sign_a_s  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign sign_b_s  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign a_neg_s   = sign_a_s & srcA[31];
  assign b_neg_s   = sign_b_s & srcB[31];
  assign mag_a_s   = a_neg_s ? (32'd0 - srcA) : srcA;
  assign mag_b_s   = b_neg_s ? (32'd0 - srcB) : srcB;
  assign div0_s    = is_div_s && (srcB == 32'd0);
  assign ovf_s     = is_div_s && !op[0] && (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);

  // In CALC, acc_r holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum_s = {1'b0, acc_r[63:32]} + {1'b0, b_r};
  assign trial_s   = {acc_r[63:32], acc_r[31]} - {1'b0, b_r};
  assign prod_s    = neg_r ? (64'd0 - acc_r) : acc_r;
  assign quo_s     = neg_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
  assign rem_s     = a_neg_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];

  // Next-state selection for the sequencing FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (div0_s || ovf_s) ? CORR : CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == 6'd31) begin
          state_s = CORR;
        end else begin
          state_s = CALC;
        end
      end
      CORR:    state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Sign correction and result selection; a divide-by-zero keeps the dividend in acc_r[31:0]
  always_comb begin
    result_s = 32'h0;
    case (op_r)
      3'b000:                 result_s = prod_s[31:0];
      3'b001, 3'b010, 3'b011: result_s = prod_s[63:32];
      3'b100, 3'b101: begin
        if (div0_r) begin
          result_s = 32'hFFFF_FFFF;
        end else if (ovf_r) begin
          result_s = 32'h8000_0000;
        end else begin
          result_s = quo_s;
        end
      end
      3'b110, 3'b111: begin
        if (div0_r) begin
          result_s = a_neg_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
        end else if (ovf_r) begin
          result_s = 32'h0;
        end else begin
          result_s = rem_s;
        end
      end
      default: result_s = 32'h0;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= 6'd0;
      acc_r    <= 64'd0;
      b_r      <= 32'd0;
      op_r     <= 3'd0;
      a_neg_r  <= 1'b0;
      neg_r    <= 1'b0;
      div0_r   <= 1'b0;
      ovf_r    <= 1'b0;
      result_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r    <= op;
            a_neg_r <= a_neg_s;
            neg_r   <= a_neg_s ^ b_neg_s;
            div0_r  <= div0_s;
            ovf_r   <= ovf_s;
            cnt_r   <= 6'd0;
            b_r     <= is_div_s ? mag_b_s : mag_a_s;
            acc_r   <= {32'd0, (is_div_s ? mag_a_s : mag_b_s)};
          end
        end
        CALC: begin
          cnt_r <= cnt_r + 6'd1;
          if (op_r[2]) begin
            if (!trial_s[32]) begin
              acc_r <= {trial_s[31:0], acc_r[30:0], 1'b1};
            end else begin
              acc_r <= {acc_r[62:0], 1'b0};
            end
          end else begin
            if (acc_r[0]) begin
              acc_r <= {mul_sum_s, acc_r[31:1]};
            end else begin
              acc_r <= {1'b0, acc_r[63:1]};
            end
          end
        end
        CORR:    result_r <= result_s;
        DONE:    ;
        default: ;
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign MDresult = result_r;

endmodule
